spi_master: RTL and testbench

SPI bus initiator for the SPI core: drives `cs_n`, `sclk` and `mosi`, and samples `miso`. It serialises one `DATA_W`-bit word per frame, MSB first, in SPI mode 0 (CPOL=0, CPHA=0). It is the counterpart of the receive-side logic, which resynchronises these same bus lines in its own clock domain. The user side is a valid/ready word handshake for transmit and a one-cycle strobe for receive.

---
 rtl/spi_master.sv | 171 +++++++++++++++++
 tb/tb_spi_master.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// spi_master: SPI mode-0 (CPOL=0, CPHA=0) bus initiator. Each accepted word is
// sent as one DATA_W-bit frame, MSB first, while the word returned on miso is
// shifted in and delivered with a one-cycle strobe.
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   tx_data, tx_valid   word to send and its request flag
//   tx_ready            idle and able to accept a request (state decode)
//   rx_data, rx_valid   last received word and its one-cycle update strobe
//   busy                frame or deselect guard in progress (= !tx_ready)
//   sclk, cs_n, mosi    registered bus outputs
//   miso                serial data from the slave
module spi_master #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int unsigned CNT_W  = $clog2(CLK_DIV);
  localparam int unsigned EDGE_W = $clog2(2 * DATA_W + 1);

  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CLK_DIV - 1);
  // GAP is one cycle shorter so the following IDLE cycle completes the
  // deselect time and a held request restarts exactly one period later.
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(CLK_DIV - 2);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LEAD  = 3'd1;
  localparam logic [2:0] S_XFER  = 3'd2;
  localparam logic [2:0] S_TRAIL = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state_q,    state_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [EDGE_W-1:0] edge_q,     edge_d;
  logic [DATA_W-1:0] tx_sh_q,    tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q,    rx_sh_d;
  logic [DATA_W-1:0] rx_data_q,  rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              sclk_q,     sclk_d;
  logic              cs_n_q,     cs_n_d;
  logic              mosi_q,     mosi_d;
  logic [EDGE_W-1:0] edge_nxt;

  // Handshake flags decode state directly.
  assign tx_ready = (state_q == S_IDLE);
  assign busy     = ~tx_ready;

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign cs_n     = cs_n_q;
  assign mosi     = mosi_q;

  assign edge_nxt = edge_q + EDGE_W'(1);

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_d     = edge_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    cs_n_d     = cs_n_q;
    mosi_d     = mosi_q;

    case (state_q)
      S_IDLE: begin
        if (tx_valid) begin
          state_d = S_LEAD;
          cnt_d   = CNT_LOAD;
          edge_d  = '0;
          tx_sh_d = tx_data;
          rx_sh_d = '0;
          cs_n_d  = 1'b0;
          mosi_d  = tx_data[DATA_W-1];
        end
      end

      // LEAD ends with the first sclk toggle, so both states share the
      // toggle logic; sclk is low throughout LEAD.
      S_LEAD, S_XFER: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d   = CNT_LOAD;
          sclk_d  = ~sclk_q;
          edge_d  = edge_nxt;
          state_d = (edge_nxt == EDGE_LAST) ? S_TRAIL : S_XFER;
          if (!sclk_q) begin
            rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
          end else if (edge_nxt != EDGE_LAST) begin
            tx_sh_d = tx_sh_q << 1;
            mosi_d  = tx_sh_q[DATA_W-2];
          end
        end
      end

      S_TRAIL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d    = S_GAP;
          cnt_d      = GAP_LOAD;
          cs_n_d     = 1'b1;
          mosi_d     = 1'b0;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
        end
      end

      S_GAP: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      edge_q     <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_q     <= edge_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      cs_n_q     <= cs_n_d;
      mosi_q     <= mosi_d;
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: bench for spi_master. A default instance (8 bit, divide-by-4)
// talks to a bus-level slave model and is compared every cycle against a
// timing model derived from the frame rules; a second instance (16 bit,
// divide-by-2) runs in loopback.
module tb_spi_master;

  localparam int unsigned W  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned W2 = 16;
  localparam int unsigned D2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst      = 1'b1;
  logic [W-1:0]  tx_data  = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready;
  logic [W-1:0]  rx_data;
  logic          rx_valid, busy, sclk, cs_n, mosi;
  logic          miso     = 1'b0;

  logic [W2-1:0] tx_data2  = '0;
  logic          tx_valid2 = 1'b0;
  logic          tx_ready2;
  logic [W2-1:0] rx_data2;
  logic          rx_valid2, busy2, sclk2, cs_n2, mosi2;

  spi_master #(.DATA_W(W), .CLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  spi_master #(.DATA_W(W2), .CLK_DIV(D2)) dut2 (
    .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
    .tx_ready(tx_ready2), .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2),
    .sclk(sclk2), .cs_n(cs_n2), .mosi(mosi2), .miso(mosi2)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;   // number of the most recent rising clk edge

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL timeout %s cycle=%0d", name, cyc);
  endtask

  // ---------------- behavioural timing model (default instance) -------------
  logic [W-1:0] slave_word = '0;   // word the slave returns in the next frame
  bit           m_act   = 1'b0;
  bit           m_ready = 1'b1;
  int           m_t0    = 0;
  logic [W-1:0] m_tx    = '0;
  logic [W-1:0] m_slv   = '0;
  logic [W-1:0] m_rxd   = '0;
  logic         m_cs    = 1'b1;
  logic         m_sclk  = 1'b0;
  logic         m_mosi  = 1'b0;
  logic         m_rxv   = 1'b0;

  always @(posedge clk) begin
    int t, tog, j;
    cyc++;
    if (rst) begin
      m_act = 1'b0;
      m_rxd = '0;
    end else if (m_ready && tx_valid) begin
      m_act = 1'b1;
      m_t0  = cyc;
      m_tx  = tx_data;
      m_slv = slave_word;
    end
    m_cs = 1'b1; m_sclk = 1'b0; m_mosi = 1'b0; m_rxv = 1'b0;
    if (m_act) begin
      t   = cyc - m_t0;
      tog = (t / D < 2 * W) ? t / D : 2 * W;         // sclk toggles made so far
      if (t < (2 * W + 1) * D) begin
        m_cs   = 1'b0;
        m_sclk = tog[0];
        j      = (tog / 2 < W - 1) ? tog / 2 : W - 1;  // bits already shifted out
        m_mosi = m_tx[W-1-j];
      end
      if (t == (2 * W + 1) * D) begin
        m_rxv = 1'b1;
        m_rxd = m_slv;
      end
      if (t >= (2 * W + 2) * D - 1) m_act = 1'b0;
    end
    m_ready = !m_act;
  end

  // ---------------- mode-0 slave on the default bus --------------------------
  int           s_bit      = 0;
  logic [W-1:0] s_word     = '0;
  logic         s_prev_cs  = 1'b1;
  logic         s_prev_sck = 1'b0;

  always @(negedge clk) begin
    if (cs_n !== 1'b0) begin
      s_bit = 0;
    end else if (s_prev_cs) begin
      s_word = slave_word;
    end else if (s_prev_sck && !sclk) begin
      s_bit++;
    end
    s_prev_cs  = cs_n;
    s_prev_sck = sclk;
    miso = (cs_n === 1'b0 && s_bit < W) ? s_word[W-1-s_bit] : 1'b0;
  end

  // ---------------- bus monitor ---------------------------------------------
  int           n_rise = 0, frame_rise = 0, n_frames = 0, n_rxv = 0;
  int           cs_fall_cyc = 0, cs_fall_prev = 0, cs_rise_cyc = 0, rxv_cyc = 0;
  logic [W-1:0] mon_bits = '0;
  logic         mon_cs = 1'b1, mon_sck = 1'b0;

  always @(negedge clk) begin
    if (cs_n === 1'b0 && mon_cs === 1'b1) begin
      n_frames++;
      frame_rise   = 0;
      cs_fall_prev = cs_fall_cyc;
      cs_fall_cyc  = cyc;
    end
    if (cs_n === 1'b1 && mon_cs === 1'b0) cs_rise_cyc = cyc;
    if (sclk === 1'b1 && mon_sck === 1'b0) begin
      n_rise++;
      if (cs_n === 1'b0) begin
        frame_rise++;
        mon_bits = {mon_bits[W-2:0], mosi};
      end
    end
    if (rx_valid === 1'b1) begin
      n_rxv++;
      rxv_cyc = cyc;
    end
    mon_cs  = cs_n;
    mon_sck = sclk;
  end

  // ---------------- per-cycle compare against the model ---------------------
  bit chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cs_n",     cs_n,     m_cs);
      chk("sclk",     sclk,     m_sclk);
      chk("mosi",     mosi,     m_mosi);
      chk("rx_valid", rx_valid, m_rxv);
      chk("rx_data",  rx_data,  m_rxd);
      chk("tx_ready", tx_ready, m_ready);
      chk("busy",     busy,     !m_ready);
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_cs(input logic lvl, input string name);
    int i = 0;
    while (cs_n !== lvl && i < 400) begin step(1); i++; end
    if (cs_n !== lvl) tmo(name);
  endtask

  task automatic wait_ready(input string name);
    int i = 0;
    while (tx_ready !== 1'b1 && i < 400) begin step(1); i++; end
    if (tx_ready !== 1'b1) tmo(name);
  endtask

  task automatic wait_rxv(input int target, input string name);
    int i = 0;
    while (n_rxv < target && i < 400) begin step(1); i++; end
    if (n_rxv < target) tmo(name);
  endtask

  task automatic wait_rise(input int target, input string name);
    int i = 0;
    while (frame_rise < target && i < 400) begin step(1); i++; end
    if (frame_rise < target) tmo(name);
  endtask

  task automatic send(input logic [W-1:0] word, input logic [W-1:0] reply);
    slave_word = reply;
    tx_data    = word;
    tx_valid   = 1'b1;
    step(1);
    tx_valid   = 1'b0;
    tx_data    = W'($urandom);
  endtask

  task automatic loop2(input logic [W2-1:0] word, input string name);
    int hs, i;
    tx_data2  = word;
    tx_valid2 = 1'b1;
    hs        = cyc + 1;
    step(1);
    tx_valid2 = 1'b0;
    tx_data2  = '0;
    i = 0;
    while (rx_valid2 !== 1'b1 && i < 400) begin step(1); i++; end
    if (rx_valid2 !== 1'b1) tmo(name);
    else begin
      chk({name, "_latency"}, cyc - hs, (2 * W2 + 1) * D2);
      chk({name, "_data"}, rx_data2, word);
      step(1);
      chk({name, "_strobe_len"}, rx_valid2, 1'b0);
    end
    i = 0;
    while (tx_ready2 !== 1'b1 && i < 400) begin step(1); i++; end
    if (tx_ready2 !== 1'b1) tmo({name, "_ready"});
  endtask

  // ---------------- test sequence -------------------------------------------
  initial begin
    int base_f, base_r, base_v;
    logic [W-1:0] sw, tw;

    // Reset then idle
    step(1);
    chk_en = 1'b1;
    step(2);
    rst = 1'b0;
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_sclk", sclk, 1'b0);
    chk("rst_mosi", mosi, 1'b0);
    chk("rst_tx_ready", tx_ready, 1'b1);
    chk("rst_rx_valid", rx_valid, 1'b0);
    chk("rst_rx_data", rx_data, 8'h00);
    step(100);
    chk("idle_rises", n_rise, 0);
    chk("idle_frames", n_frames, 0);

    // Single frame 0xA5 out, 0x3C back
    send(8'hA5, 8'h3C);
    wait_rxv(1, "single_rxv");
    chk("single_rxv_edge", rxv_cyc - cs_fall_cyc, 68);
    chk("single_rx_data", rx_data, 8'h3C);
    chk("single_mosi_bits", mon_bits, 8'hA5);
    chk("single_rises", frame_rise, 8);
    step(1);
    chk("single_rxv_len", rx_valid, 1'b0);
    wait_ready("single_ready");
    step(3);

    // Back-to-back with tx_valid held
    base_f     = n_frames;
    base_v     = n_rxv;
    slave_word = 8'h5A;
    tx_data    = 8'h01;
    tx_valid   = 1'b1;
    wait_cs(1'b0, "b2b_first");
    tx_data    = 8'hFF;
    wait_cs(1'b1, "b2b_first_end");
    chk("b2b_first_bits", mon_bits, 8'h01);
    slave_word = 8'hC3;
    wait_cs(1'b0, "b2b_second");
    tx_valid   = 1'b0;
    chk("b2b_period", cs_fall_cyc - cs_fall_prev, 72);
    chk("b2b_deselect_ge_div", (cs_fall_cyc - cs_rise_cyc) >= D, 1'b1);
    wait_rxv(base_v + 2, "b2b_rxv");
    chk("b2b_rx_data", rx_data, 8'hC3);
    chk("b2b_second_bits", mon_bits, 8'hFF);
    chk("b2b_frames", n_frames - base_f, 2);
    wait_ready("b2b_ready");
    step(2);

    // Request during XFER is ignored
    base_f = n_frames;
    base_v = n_rxv;
    send(8'h33, 8'h77);
    wait_rise(2, "busy_xfer");
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
    wait_rxv(base_v + 1, "busy_rxv");
    chk("busy_rx_data", rx_data, 8'h77);
    chk("busy_mosi_bits", mon_bits, 8'h33);
    step(30);
    chk("busy_frames", n_frames - base_f, 1);

    // Reset after the 3rd rising sclk
    send(8'hC6, 8'hE1);
    wait_rise(3, "midrst_rise3");
    base_v = n_rxv;
    rst    = 1'b1;
    step(1);
    chk("midrst_cs_n", cs_n, 1'b1);
    chk("midrst_sclk", sclk, 1'b0);
    chk("midrst_rx_data", rx_data, 8'h00);
    chk("midrst_tx_ready", tx_ready, 1'b1);
    rst    = 1'b0;
    base_r = n_rise;
    step(80);
    chk("midrst_no_rxv", n_rxv - base_v, 0);
    chk("midrst_no_edges", n_rise - base_r, 0);
    send(8'h96, 8'h69);
    wait_rxv(base_v + 1, "midrst_next_rxv");
    chk("midrst_next_rx", rx_data, 8'h69);
    chk("midrst_next_bits", mon_bits, 8'h96);
    wait_ready("midrst_ready");

    // Random frames with ignored mid-frame requests
    for (int f = 0; f < 8; f++) begin
      sw     = W'($urandom);
      tw     = W'($urandom);
      base_v = n_rxv;
      send(tw, sw);
      step(int'($urandom_range(5, 60)));
      tx_data  = W'($urandom);
      tx_valid = 1'b1;
      step(1);
      tx_valid = 1'b0;
      wait_rxv(base_v + 1, "rand_rxv");
      chk("rand_rx_data", rx_data, sw);
      chk("rand_mosi_bits", mon_bits, tw);
      wait_ready("rand_ready");
      step(int'($urandom_range(0, 3)));
    end

    // Minimum divider, 16-bit loopback
    loop2(16'h8001, "loop_8001");
    loop2(W2'($urandom), "loop_rand");

    step(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
